// File: rtl/psum_ofifo_pkg.sv
// rtl/psum_ofifo_pkg.sv - shared constants and column-slice helper (package ofifo_pkg)
package ofifo_pkg;

  localparam int PSUM_BW         = 16;
  localparam int COL             = 8;
  localparam int OFIFO_DEPTH_LOG = 6;

  // LSB of column j inside a flat col*bw bus; shared with mac_row/mac_array
  function automatic int col_lsb(input int j, input int bw);
    return j * bw;
  endfunction

endpackage

// File: rtl/psum_ofifo_if.sv
// rtl/psum_ofifo_if.sv - psum output FIFO bus: column writes in, aligned rows out
interface psum_ofifo_if
  import ofifo_pkg::*;
#(
  parameter int COL     = ofifo_pkg::COL,
  parameter int PSUM_BW = ofifo_pkg::PSUM_BW
) ();

  logic [PSUM_BW*COL-1:0] in;
  logic [COL-1:0]         wr;
  logic                   rd;
  logic [PSUM_BW*COL-1:0] out;
  logic                   o_valid;
  logic                   o_ready;
  logic                   o_full;
  logic                   o_overflow;

  // master: mac row / consumer side driving the collector
  modport master (
    output in, wr, rd,
    input  out, o_valid, o_ready, o_full, o_overflow
  );

  // slave: the collector itself
  modport slave (
    input  in, wr, rd,
    output out, o_valid, o_ready, o_full, o_overflow
  );

endinterface

// File: rtl/psum_ofifo_fifo_col.sv
// rtl/psum_ofifo_fifo_col.sv - single-column single-clock FIFO (module fifo_col)
module fifo_col
  import ofifo_pkg::*;
#(
  parameter int BW        = PSUM_BW,
  parameter int DEPTH_LOG = OFIFO_DEPTH_LOG
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic          rd,     // accepted pop; caller guarantees !empty
  input  logic [BW-1:0] in,
  output logic [BW-1:0] out,    // head entry, valid whenever !empty
  output logic          empty,
  output logic          full,
  output logic          drop    // write lost on a full column this cycle
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] PTR_ONE = {{DEPTH_LOG{1'b0}}, 1'b1};

  logic [DEPTH_LOG:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG:0] wr_ptr_q, wr_ptr_d;
  logic [BW-1:0]      mem_q [DEPTH];
  logic               wr_en;

  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = (rd_ptr_q[DEPTH_LOG-1:0] == wr_ptr_q[DEPTH_LOG-1:0]) &&
                 (rd_ptr_q[DEPTH_LOG] != wr_ptr_q[DEPTH_LOG]);
  // a same-cycle pop frees the slot being written, so full does not block it
  assign wr_en = wr && (!full || rd);
  assign drop  = wr && full && !rd;
  assign out   = mem_q[rd_ptr_q[DEPTH_LOG-1:0]];

  // next pointer values; wrap bit rolls over naturally
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (rd)    rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
  end

  // pointer registers, cleared by reset so buffered data is discarded
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // storage array; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[DEPTH_LOG-1:0]] <= in;
  end

endmodule

// File: rtl/psum_ofifo.sv
// rtl/psum_ofifo.sv - MAC array south-edge psum collector; optional ReLU via OFIFO_RELU_EN
module psum_ofifo
  import ofifo_pkg::*;
#(
  parameter int col       = COL,
  parameter int psum_bw   = PSUM_BW,
  parameter int depth_log = OFIFO_DEPTH_LOG
) (
  input  logic        clk,
  input  logic        reset,
  psum_ofifo_if.slave bus
);

  logic [col-1:0]         empty_w;
  logic [col-1:0]         full_w;
  logic [col-1:0]         drop_w;
  logic [psum_bw*col-1:0] head_w;
  logic [psum_bw*col-1:0] row_w;
  logic                   pop_w;

  logic [psum_bw*col-1:0] out_q, out_d;
  logic                   o_valid_q, o_valid_d;
  logic                   overflow_q, overflow_d;

  // all flags come from pointer state only, never from rd/wr
  assign bus.o_ready    = &(~empty_w);
  assign bus.o_full     = |full_w;
  assign bus.o_overflow = overflow_q;
  assign bus.out        = out_q;
  assign bus.o_valid    = o_valid_q;
  assign pop_w          = bus.rd && bus.o_ready;

  for (genvar j = 0; j < col; j++) begin : g_col
    fifo_col #(
      .BW        (psum_bw),
      .DEPTH_LOG (depth_log)
    ) u_col (
      .clk   (clk),
      .reset (reset),
      .wr    (bus.wr[j]),
      .rd    (pop_w),
      .in    (bus.in[col_lsb(j, psum_bw) +: psum_bw]),
      .out   (head_w[col_lsb(j, psum_bw) +: psum_bw]),
      .empty (empty_w[j]),
      .full  (full_w[j]),
      .drop  (drop_w[j])
    );
  end

  // output word shaping: raw psums, or ReLU-clamped when enabled
  always_comb begin
    row_w = head_w;
`ifdef OFIFO_RELU_EN
    for (int j = 0; j < col; j++) begin
      if (head_w[col_lsb(j, psum_bw) + psum_bw - 1]) row_w[col_lsb(j, psum_bw) +: psum_bw] = '0;
    end
`endif
  end

  // next state of the out register, pop strobe and sticky overflow
  always_comb begin
    out_d      = out_q;
    o_valid_d  = pop_w;
    overflow_d = overflow_q | (|drop_w);
    if (pop_w) out_d = row_w;
  end

  // output and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q      <= '0;
      o_valid_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      o_valid_q  <= o_valid_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_psum_ofifo.sv
// tb/tb_psum_ofifo.sv - scoreboard bench for psum_ofifo
module tb_psum_ofifo;
  import ofifo_pkg::*;

  localparam int C  = 8;
  localparam int W  = 16;
  localparam int RW = C * W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  psum_ofifo_if #(.COL(C), .PSUM_BW(W)) bus ();

  psum_ofifo #(.col(C), .psum_bw(W), .depth_log(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q [$];

  function automatic logic [W-1:0] word_exp(input logic [W-1:0] v);
`ifdef OFIFO_RELU_EN
    return v[W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [RW-1:0] exp_row(input logic [RW-1:0] raw);
    logic [RW-1:0] r;
    for (int j = 0; j < C; j++) r[j*W +: W] = word_exp(raw[j*W +: W]);
    return r;
  endfunction

  function automatic logic [RW-1:0] fill_row(input logic [W-1:0] v);
    logic [RW-1:0] r;
    for (int j = 0; j < C; j++) r[j*W +: W] = v;
    return r;
  endfunction

  function automatic logic [RW-1:0] wrap_row(input int r);
    logic [RW-1:0] x;
    for (int j = 0; j < C; j++) x[j*W +: W] = 16'(r * 8 + j) ^ ((r % 2 == 1) ? 16'h8000 : 16'h0000);
    return x;
  endfunction

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input logic [RW-1:0] v, input logic [C-1:0] mask);
    bus.in = v;
    bus.wr = mask;
    tick();
    bus.wr = '0;
  endtask

  task automatic pop(input logic [RW-1:0] raw);
    exp_q.push_back(exp_row(raw));
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
  endtask

  // monitor: every presented row must match the oldest expected row
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop actual=%h required=none", bus.out);
      end else begin
        check("pop_row", bus.out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] sk;
    logic [RW-1:0] rl;
    reset  = 1'b1;
    bus.in = '0;
    bus.wr = '0;
    bus.rd = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("reset_ready", bus.o_ready, 0);
    check("reset_full", bus.o_full, 0);
    check("reset_valid", bus.o_valid, 0);
    check("reset_overflow", bus.o_overflow, 0);
    check("reset_out", bus.out, 0);

    // skewed wavefront fill
    sk = '0;
    for (int j = 0; j < C; j++) begin
      logic [RW-1:0] r;
      r = '0;
      r[j*W +: W] = 16'(j + 1);
      sk[j*W +: W] = 16'(j + 1);
      push_row(r, 8'(1 << j));
      check("skew_ready", bus.o_ready, (j == C - 1) ? 1 : 0);
    end
    pop(sk);
    check("skew_ready_after_pop", bus.o_ready, 0);

    // read with column 7 still empty is ignored
    push_row(fill_row(16'h0055), 8'h7F);
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    check("empty_rd_ready", bus.o_ready, 0);
    check("empty_rd_valid", bus.o_valid, 0);
    check("empty_rd_out_hold", bus.out, exp_row(sk));
    push_row(fill_row(16'h0055), 8'h80);
    check("empty_rd_ready_col7", bus.o_ready, 1);
    pop(fill_row(16'h0055));
    check("empty_rd_drained", bus.o_ready, 0);

    // fill to full, then overflow
    for (int i = 0; i < 64; i++) begin
      push_row(fill_row(16'(i)), 8'hFF);
      if (i == 62) check("full_at_63", bus.o_full, 0);
      if (i == 63) check("full_at_64", bus.o_full, 1);
    end
    check("no_overflow_at_64", bus.o_overflow, 0);
    push_row(fill_row(16'd99), 8'hFF);
    check("overflow_set", bus.o_overflow, 1);
    check("overflow_full", bus.o_full, 1);
    for (int i = 0; i < 64; i++) pop(fill_row(16'(i)));
    check("overflow_drained", bus.o_ready, 0);
    check("overflow_sticky", bus.o_overflow, 1);

    // async reset mid-stream with 3 rows buffered and a pop in flight
    for (int i = 0; i < 3; i++) push_row(fill_row(16'(16'h0100 + i)), 8'hFF);
    check("mid_ready_before", bus.o_ready, 1);
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("mid_reset_ready", bus.o_ready, 0);
    check("mid_reset_valid", bus.o_valid, 0);
    check("mid_reset_out", bus.out, 0);
    check("mid_reset_overflow", bus.o_overflow, 0);
    tick();
    reset = 1'b0;
    repeat (2) tick();
    check("mid_reset_after_ready", bus.o_ready, 0);

    // simultaneous pop and write while full
    for (int i = 0; i < 64; i++) push_row(fill_row(16'(i)), 8'hFF);
    check("sim_full", bus.o_full, 1);
    for (int k = 0; k < 10; k++) begin
      exp_q.push_back(exp_row(fill_row(16'(k))));
      bus.in = fill_row(16'(64 + k));
      bus.wr = 8'hFF;
      bus.rd = 1'b1;
      tick();
    end
    bus.wr = '0;
    bus.rd = 1'b0;
    check("sim_still_full", bus.o_full, 1);
    check("sim_no_overflow", bus.o_overflow, 0);
    for (int i = 10; i < 74; i++) pop(fill_row(16'(i)));
    check("sim_drained", bus.o_ready, 0);

    // signed words: -10, +10, most negative, most positive
    rl = fill_row(16'h0000);
    rl[0*W +: W] = 16'hFFF6;
    rl[1*W +: W] = 16'h000A;
    rl[2*W +: W] = 16'h8000;
    rl[3*W +: W] = 16'h7FFF;
    push_row(rl, 8'hFF);
    pop(rl);

    // 200-row streaming through pointer wrap
    for (int r = 0; r < 200; r++) begin
      bus.in = wrap_row(r);
      bus.wr = 8'hFF;
      bus.rd = 1'b0;
      if (r > 0) begin
        exp_q.push_back(exp_row(wrap_row(r - 1)));
        bus.rd = 1'b1;
      end
      tick();
    end
    bus.wr = '0;
    pop(wrap_row(199));
    check("wrap_drained", bus.o_ready, 0);

    for (int n = 0; n < 20 && exp_q.size() > 0; n++) tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
